i2c_slave_rx: RTL and testbench

- I2C target (slave) receiver: the responder at the far end of the bus driven by i2c_master_control.
- Watches SCL/SDA and detects START/STOP.
- Decodes the 7-bit address + R/W bit and ACKs its own write address.
- Deserialises the data bytes that follow and presents each one on a parallel port with a ready/valid-style handshake.
- Sits beside i2c_master_control on the shared open-drain bus and serves as the in-testbench loopback target and scoreboard tap.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_bus_sync.sv | 65 ++++++
 rtl/i2c_slave_rx.sv | 189 ++++++++++++++++++
 tb/tb_i2c_slave_rx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared I2C definitions: address/byte widths and the target-receiver FSM
// state type. Imported by i2c_bus_sync and i2c_slave_rx.
// ---------------------------------------------------------------------------
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    DATA     = 3'd3,
    DATA_ACK = 3'd4,
    IGNORE   = 3'd5
  } i2c_slv_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
// Synchronises the asynchronous SCL/SDA bus lines into the clk domain and
// derives bus events from the synchronised levels.
//
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   scl, sda    raw bus lines
//   scl_s       synchronised SCL level
//   sda_s       synchronised SDA level
//   scl_rise    one-cycle pulse: SCL rising edge
//   scl_fall    one-cycle pulse: SCL falling edge
//   start_det   one-cycle pulse: SDA fell while SCL held high
//   stop_det    one-cycle pulse: SDA rose while SCL held high
// ---------------------------------------------------------------------------
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2  // must be >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;

  // Flops reset to 1 (idle bus level) so releasing reset on an idle bus
  // cannot fabricate an edge, START or STOP.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;

  // SCL must be high both before and after the SDA edge, so an SDA change
  // that lands in the same cycle as an SCL edge is treated as ordinary data.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_rx.sv
// ---------------------------------------------------------------------------
// i2c_slave_rx
// I2C target receiver. Detects START/STOP, decodes the 7-bit address plus
// R/W bit, ACKs its own write address, deserialises the following data bytes
// and hands each one to a parallel sink. Reads are NACKed.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset (also releases SDA at once)
//   scl         bus clock (input only, no stretching)
//   sda_in      bus data as seen on the wire
//   sda_oe      1 = pull SDA low (ACK), 0 = release
//   rx_ready    sink can accept a byte
//   data_out    last accepted byte
//   data_valid  one-cycle pulse: data_out is new
//   addr_match  one-cycle pulse: own write address ACKed
//   overflow    one-cycle pulse: byte dropped because rx_ready was low
//   busy        high from own-address ACK until STOP
// ---------------------------------------------------------------------------
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  input  logic                  sda_in,
  output logic                  sda_oe,
  input  logic                  rx_ready,
  output logic [I2C_BYTE_W-1:0] data_out,
  output logic                  data_valid,
  output logic                  addr_match,
  output logic                  overflow,
  output logic                  busy
);

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda_in),
    .scl_s    (scl_s),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  i2c_slv_state_e        state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d;
  logic [I2C_BYTE_W-1:0] data_out_q, data_out_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  data_valid_q, data_valid_d;
  logic                  addr_match_q, addr_match_d;
  logic                  overflow_q, overflow_d;
  logic                  busy_q, busy_d;

  logic byte_done;
  assign byte_done = (bit_cnt_q == 4'(I2C_BYTE_W));

  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch instead of holding the flop.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    sda_oe_d     = sda_oe_q;
    data_valid_d = 1'b0;
    addr_match_d = 1'b0;
    overflow_d   = 1'b0;
    busy_d       = busy_q;

    // Bus conditions override any SCL edge seen in the same cycle.
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;

        ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[I2C_BYTE_W-2:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && byte_done) begin
            // shift_q = {addr[6:0], rw}; only own-address writes are ACKed.
            if (shift_q[I2C_BYTE_W-1:1] == SLAVE_ADDR && !shift_q[0]) begin
              sda_oe_d     = 1'b1;
              addr_match_d = 1'b1;
              busy_d       = 1'b1;
              state_d      = ADDR_ACK;
            end else begin
              state_d = IGNORE;
            end
          end
        end

        // Entered on the 8th fall; the next fall closes the 9th (ACK) clock.
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = DATA;
          end
        end

        DATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[I2C_BYTE_W-2:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && byte_done) begin
            if (rx_ready) begin
              data_out_d   = shift_q;
              data_valid_d = 1'b1;
              sda_oe_d     = 1'b1;
              state_d      = DATA_ACK;
            end else begin
              overflow_d = 1'b1;
              state_d    = IGNORE;
            end
          end
        end

        DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = DATA;
          end
        end

        IGNORE: sda_oe_d = 1'b0;

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // Asynchronous reset drops sda_oe immediately, releasing the bus mid-ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      sda_oe_q     <= 1'b0;
      data_valid_q <= 1'b0;
      addr_match_q <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      sda_oe_q     <= sda_oe_d;
      data_valid_q <= data_valid_d;
      addr_match_q <= addr_match_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign addr_match = addr_match_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_rx
// Bench for i2c_slave_rx: an in-bench bus master drives SCL/SDA over an
// open-drain wire, and a transaction-level model predicts ACKs, pulse counts
// and the final data_out for each write.
// ---------------------------------------------------------------------------
module tb_i2c_slave_rx;

  localparam int Q = 8;  // clk cycles per quarter of an SCL bit

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda;
  logic       sda_w;
  logic       sda_oe;
  logic       rx_ready;
  logic [7:0] data_out;
  logic       data_valid, addr_match, overflow, busy;

  // Open-drain wire: master's level ANDed with the target's pull-down.
  assign sda_w = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_rx #(
    .SLAVE_ADDR (7'h50),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (m_scl),
    .sda_in    (sda_w),
    .sda_oe    (sda_oe),
    .rx_ready  (rx_ready),
    .data_out  (data_out),
    .data_valid(data_valid),
    .addr_match(addr_match),
    .overflow  (overflow),
    .busy      (busy)
  );

  // Pulse monitor: counts cycles each pulse output is high.
  int am_tot = 0, dv_tot = 0, ov_tot = 0;
  always @(negedge clk) begin
    if (addr_match) am_tot <= am_tot + 1;
    if (data_valid) dv_tot <= dv_tot + 1;
    if (overflow)   ov_tot <= ov_tot + 1;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- bus master primitives ----------------
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b, output logic sampled);
    m_sda = b;    wait_q();
    m_scl = 1'b1; wait_q();
    sampled = sda_w;
    m_scl = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);  // 9th clock: master releases, target may pull low
    acked = ~s;
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [3:0] ack;    // bit0 = address, bit i = data byte i-1
    int         valid;
    int         ovf;
    logic [7:0] dout;
  } exp_t;

  function automatic exp_t model(input logic [7:0] addr, input int n,
                                 input logic [23:0] bytes, input logic [2:0] rdy,
                                 input logic [7:0] prev_dout);
    exp_t e;
    e.ack = '0; e.valid = 0; e.ovf = 0; e.dout = prev_dout;
    if (addr == 8'hA0) begin  // 0x50, write
      e.ack[0] = 1'b1;
      for (int i = 0; i < n; i++) begin
        if (rdy[i]) begin
          e.ack[i+1] = 1'b1;
          e.valid++;
          e.dout = bytes[i*8 +: 8];
        end else begin
          e.ovf++;
          break;  // target ignores the rest of the transfer
        end
      end
    end
    return e;
  endfunction

  // One complete write: START, address, n bytes, STOP, then compare.
  task automatic run_txn(input string tag, input logic [7:0] addr, input int n,
                         input logic [23:0] bytes, input logic [2:0] rdy,
                         input exp_t e);
    int a0, v0, o0;
    logic [3:0] ack;
    logic a;
    a0 = am_tot; v0 = dv_tot; o0 = ov_tot;
    ack = '0;
    bus_start();
    send_byte(addr, a);
    ack[0] = a;
    for (int i = 0; i < n; i++) begin
      rx_ready = rdy[i];
      send_byte(bytes[i*8 +: 8], a);
      ack[i+1] = a;
    end
    check({tag, " busy_before_stop"}, 32'(busy), 32'(e.ack[0]));
    bus_stop();
    repeat (6) @(negedge clk);
    rx_ready = 1'b1;
    check({tag, " ack_bits"},   32'(ack), 32'(e.ack));
    check({tag, " addr_match"}, 32'(am_tot - a0), 32'(e.ack[0]));
    check({tag, " data_valid"}, 32'(dv_tot - v0), 32'(e.valid));
    check({tag, " overflow"},   32'(ov_tot - o0), 32'(e.ovf));
    check({tag, " data_out"},   32'(data_out), 32'(e.dout));
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    check({tag, " sda_oe_idle"}, 32'(sda_oe), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  addr;
    int          n;
    logic [23:0] bytes;
    logic [2:0]  rdy;
    logic [3:0]  exp_ack;
    int          exp_valid;
    int          exp_ovf;
    logic [7:0]  exp_dout;
  } vec_t;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[5];
    exp_t       e;
    logic [7:0] exp_dout;
    logic       a, s;
    int         a0, v0;

    // Expected values worked out by hand; data_out carries across entries.
    vecs[0] = '{8'hA0, 1, 24'h0000A5, 3'b111, 4'b0011, 1, 0, 8'hA5}; // own write
    vecs[1] = '{8'hA2, 1, 24'h00003C, 3'b111, 4'b0000, 0, 0, 8'hA5}; // addr 0x51
    vecs[2] = '{8'hA1, 1, 24'h0000FF, 3'b111, 4'b0000, 0, 0, 8'hA5}; // read 0x50
    vecs[3] = '{8'hA0, 2, 24'h003412, 3'b001, 4'b0011, 1, 1, 8'h12}; // overflow
    vecs[4] = '{8'hA0, 3, 24'hFF8001, 3'b111, 4'b1111, 3, 0, 8'hFF}; // 3 bytes

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("rst sda_oe",     32'(sda_oe), 32'd0);
    check("rst data_out",   32'(data_out), 32'd0);
    check("rst data_valid", 32'(data_valid), 32'd0);
    check("rst addr_match", 32'(addr_match), 32'd0);
    check("rst overflow",   32'(overflow), 32'd0);
    check("rst busy",       32'(busy), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);

    // ---- table-driven vectors ----
    for (int i = 0; i < 5; i++) begin
      e.ack = vecs[i].exp_ack; e.valid = vecs[i].exp_valid;
      e.ovf = vecs[i].exp_ovf; e.dout = vecs[i].exp_dout;
      run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].n, vecs[i].bytes,
              vecs[i].rdy, e);
    end
    exp_dout = 8'hFF;

    // ---- repeated START after 4 data bits ----
    a0 = am_tot; v0 = dv_tot;
    bus_start();
    send_byte(8'hA0, a);
    check("rs first addr ack", 32'(a), 32'd1);
    for (int i = 0; i < 4; i++) send_bit(1'(i), s);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
    send_byte(8'hA0, a);
    check("rs second addr ack", 32'(a), 32'd1);
    send_byte(8'h7E, a);
    check("rs data ack", 32'(a), 32'd1);
    bus_stop();
    repeat (6) @(negedge clk);
    check("rs addr_match count", 32'(am_tot - a0), 32'd2);
    check("rs data_valid count", 32'(dv_tot - v0), 32'd1);
    check("rs data_out", 32'(data_out), 32'h7E);
    exp_dout = 8'h7E;

    // ---- randomized writes against the model ----
    for (int t = 0; t < 24; t++) begin
      logic [7:0]  addr;
      logic [23:0] bytes;
      logic [2:0]  rdy;
      int          n;
      addr  = ($urandom_range(0, 1) == 0) ? 8'hA0 : 8'($urandom_range(0, 255));
      n     = $urandom_range(1, 3);
      bytes = 24'($urandom);
      rdy   = 3'($urandom) | 3'($urandom);
      e = model(addr, n, bytes, rdy, exp_dout);
      run_txn($sformatf("rnd%0d", t), addr, n, bytes, rdy, e);
      exp_dout = e.dout;
    end

    // ---- reset asserted while the target drives the address ACK ----
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(8'hA0 >> i, s);
    check("ack sda_oe before rst", 32'(sda_oe), 32'd1);
    check("ack busy before rst",   32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("async rst sda_oe", 32'(sda_oe), 32'd0);
    check("async rst busy",   32'(busy), 32'd0);
    check("async rst data_out", 32'(data_out), 32'd0);
    m_scl = 1'b1; m_sda = 1'b1;
    wait_q();
    rst = 1'b0;
    wait_q();
    exp_dout = 8'h00;
    e = model(8'hA0, 1, 24'h0000C3, 3'b111, exp_dout);
    run_txn("post_rst", 8'hA0, 1, 24'h0000C3, 3'b111, e);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
